count_monitor: RTL

Downstream checker for the 4-bit free-running up-counter. It samples the counter value on the system clock and verifies every change is a +1 step modulo 2^WIDTH. It counts wrap-arounds and step errors, and flags a stall when the value does not change within a programmable number of cycles. It sits between the counter output and the board LEDs/debug header, giving the lab bench a self-checking observation point.

---
 rtl/count_monitor_if.sv | 25 ++
 rtl/count_monitor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/count_monitor_if.sv
// Observation bus between the counter under test and count_monitor.
// master: the counter side / bench driving count_in and clear.
// slave: the monitor consuming the count and producing flags and counters.
interface count_monitor_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] count_in;
  logic             clear;
  logic             step_err;
  logic             wrap_pulse;
  logic             stall;
  logic [7:0]       err_count;
  logic [7:0]       wrap_count;
  logic [WIDTH-1:0] last_value;

  modport master (
    output count_in, clear,
    input  step_err, wrap_pulse, stall, err_count, wrap_count, last_value
  );

  modport slave (
    input  count_in, clear,
    output step_err, wrap_pulse, stall, err_count, wrap_count, last_value
  );
endinterface

// File: rtl/count_monitor.sv
// Checks that an observed up-counter only ever steps by +1 (mod 2^WIDTH).
// Latency: input change to flag/counter update is 2 clk edges (sample, then compare).
// No backpressure: the monitor accepts a new sample every cycle.
module count_monitor #(
  parameter int WIDTH     = 4,
  parameter int STALL_MAX = 64
) (
  input  logic            clk,
  input  logic            rst,
  count_monitor_if.slave  mon
);

  localparam int CW = $clog2(STALL_MAX);
  localparam logic [CW-1:0]    STALL_PRE  = CW'(STALL_MAX - 2);
  localparam logic [CW-1:0]    STALL_LAST = CW'(STALL_MAX - 1);
  localparam logic [WIDTH-1:0] TOP_VAL    = '1;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    TRACK   = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             s_vld_q, s_vld_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    stall_cnt_q, stall_cnt_d;
  logic             step_err_q, step_err_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [7:0]       wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0] prev_inc;

  assign prev_inc = prev_q + 1'b1;

  // Sample stage, comparison, FSM next state and counter updates.
  always_comb begin
    s_d          = mon.count_in;
    // s only holds a real sample after the first post-reset edge; SYNC waits for it.
    s_vld_d      = 1'b1;
    state_d      = state_q;
    prev_d       = prev_q;
    stall_cnt_d  = stall_cnt_q;
    step_err_d   = 1'b0;
    wrap_pulse_d = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    case (state_q)
      SYNC: begin
        if (s_vld_q) begin
          prev_d      = s_q;
          stall_cnt_d = '0;
          state_d     = TRACK;
        end
      end
      TRACK, STALLED: begin
        if (s_q == prev_q) begin
          if (state_q == TRACK) begin
            if (stall_cnt_q == STALL_PRE) begin
              state_d     = STALLED;
              stall_cnt_d = STALL_LAST;
            end else begin
              stall_cnt_d = stall_cnt_q + 1'b1;
            end
          end
        end else begin
          // Any change leaves STALLED and is classified in the same cycle.
          state_d     = TRACK;
          prev_d      = s_q;
          stall_cnt_d = '0;
          if (s_q == prev_inc) begin
            if (prev_q == TOP_VAL) begin
              wrap_pulse_d = 1'b1;
              wrap_count_d = wrap_count_q + 8'd1;
            end
          end else begin
            step_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase

    // clear wins over a coincident increment; pulses are unaffected.
    if (mon.clear) begin
      err_count_d  = 8'd0;
      wrap_count_d = 8'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      s_q          <= '0;
      s_vld_q      <= 1'b0;
      prev_q       <= '0;
      stall_cnt_q  <= '0;
      step_err_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= 8'd0;
      wrap_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      s_vld_q      <= s_vld_d;
      prev_q       <= prev_d;
      stall_cnt_q  <= stall_cnt_d;
      step_err_q   <= step_err_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign mon.step_err   = step_err_q;
  assign mon.wrap_pulse = wrap_pulse_q;
  assign mon.stall      = (state_q == STALLED);
  assign mon.err_count  = err_count_q;
  assign mon.wrap_count = wrap_count_q;
  assign mon.last_value = prev_q;

endmodule
